// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Latency: accept -> response valid ALU_LATENCY+1 cycles later; one op in flight, response held until taken.
module alu_arbiter #(
    parameter int DATA_W      = 8,
    parameter int SEL_W       = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [SEL_W-1:0]  req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [SEL_W-1:0]  req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [SEL_W-1:0]  alu_component_select,
    output logic [DATA_W-1:0] alu_input_1,
    output logic [DATA_W-1:0] alu_input_2,
    input  logic [DATA_W-1:0] alu_output_1,
    output logic              busy
);

    localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q;
    logic [SEL_W-1:0]  op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] result_q;
    logic              owner_q;
    logic              last_grant_q;
    logic [CNT_W-1:0]  cnt_q;

    logic grant_vld;
    logic grant_port;
    logic is_idle;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        grant_vld  = 1'b0;
        grant_port = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_vld  = 1'b1;
            grant_port = ~last_grant_q;
        end else if (req0_valid) begin
            grant_vld  = 1'b1;
            grant_port = 1'b0;
        end else if (req1_valid) begin
            grant_vld  = 1'b1;
            grant_port = 1'b1;
        end
    end

    assign is_idle = (state_q == IDLE);

    // Ready is forced low while in reset even though requesters may already be valid.
    assign req0_ready = rst_n & is_idle & grant_vld & ~grant_port;
    assign req1_ready = rst_n & is_idle & grant_vld &  grant_port;

    assign rsp0_valid = (state_q == RESP) & ~owner_q;
    assign rsp1_valid = (state_q == RESP) &  owner_q;
    assign rsp0_data  = result_q;
    assign rsp1_data  = result_q;

    assign alu_component_select = op_q;
    assign alu_input_1          = a_q;
    assign alu_input_2          = b_q;
    assign busy                 = ~is_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        op_q    <= grant_port ? req1_op : req0_op;
                        a_q     <= grant_port ? req1_a  : req0_a;
                        b_q     <= grant_port ? req1_b  : req0_b;
                        owner_q <= grant_port;
                        cnt_q   <= CNT_INIT;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        result_q     <= alu_output_1;
                        last_grant_q <= owner_q;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (owner_q ? rsp1_ready : rsp0_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a latency-1 instance for arbitration/backpressure/reset, a latency-3 instance for settle time.
module tb_alu_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [3:0] req0_op, req1_op, alu_sel;
    logic [7:0] req0_a, req0_b, req1_a, req1_b, rsp0_data, rsp1_data;
    logic [7:0] alu_in1, alu_in2, alu_out;
    logic       busy;

    logic       x_req0_valid, x_req0_ready, x_rsp0_valid, x_rsp0_ready;
    logic       x_req1_valid, x_req1_ready, x_rsp1_valid, x_rsp1_ready;
    logic [3:0] x_req0_op, x_req1_op, x_alu_sel;
    logic [7:0] x_req0_a, x_req0_b, x_req1_a, x_req1_b, x_rsp0_data, x_rsp1_data;
    logic [7:0] x_alu_in1, x_alu_in2, x_alu_out;
    logic       x_busy;

    int total = 0;
    int bad   = 0;

    function automatic logic [7:0] alu_f(input logic [3:0] s, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        case (s)
            4'd0:    r = x + y;
            4'd1:    r = x * y;
            default: r = x;
        endcase
        return r;
    endfunction

    assign alu_out   = alu_f(alu_sel, alu_in1, alu_in2);
    assign x_alu_out = alu_f(x_alu_sel, x_alu_in1, x_alu_in2);

    alu_arbiter #(.DATA_W(8), .SEL_W(4), .ALU_LATENCY(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_component_select(alu_sel), .alu_input_1(alu_in1), .alu_input_2(alu_in2),
        .alu_output_1(alu_out), .busy(busy)
    );

    alu_arbiter #(.DATA_W(8), .SEL_W(4), .ALU_LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(x_req0_valid), .req0_ready(x_req0_ready), .req0_op(x_req0_op),
        .req0_a(x_req0_a), .req0_b(x_req0_b),
        .rsp0_valid(x_rsp0_valid), .rsp0_ready(x_rsp0_ready), .rsp0_data(x_rsp0_data),
        .req1_valid(x_req1_valid), .req1_ready(x_req1_ready), .req1_op(x_req1_op),
        .req1_a(x_req1_a), .req1_b(x_req1_b),
        .rsp1_valid(x_rsp1_valid), .rsp1_ready(x_rsp1_ready), .rsp1_data(x_rsp1_data),
        .alu_component_select(x_alu_sel), .alu_input_1(x_alu_in1), .alu_input_2(x_alu_in2),
        .alu_output_1(x_alu_out), .busy(x_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy0"}, 8'(req0_ready), 8'd0);
        chk({tag, "_rdy1"}, 8'(req1_ready), 8'd0);
        chk({tag, "_rv0"},  8'(rsp0_valid), 8'd0);
        chk({tag, "_rv1"},  8'(rsp1_valid), 8'd0);
        chk({tag, "_rd0"},  rsp0_data, 8'd0);
        chk({tag, "_rd1"},  rsp1_data, 8'd0);
        chk({tag, "_sel"},  8'(alu_sel), 8'd0);
        chk({tag, "_in1"},  alu_in1, 8'd0);
        chk({tag, "_in2"},  alu_in2, 8'd0);
        chk({tag, "_busy"}, 8'(busy), 8'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; rsp0_ready = 1'b0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; rsp1_ready = 1'b0;
        x_req0_valid = 1'b0; x_req0_op = '0; x_req0_a = '0; x_req0_b = '0; x_rsp0_ready = 1'b0;
        x_req1_valid = 1'b0; x_req1_op = '0; x_req1_a = '0; x_req1_b = '0; x_rsp1_ready = 1'b0;

        // Test 1: simple add on port 0, valid already high during reset
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 8'h05; req0_b = 8'h03; rsp0_ready = 1'b1;
        #1;
        chk_all_zero("t1_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t1_accept_rdy0", 8'(req0_ready), 8'd1);
        chk("t1_accept_rdy1", 8'(req1_ready), 8'd0);
        @(negedge clk);
        req0_valid = 1'b0; req0_a = 8'hFF;
        #1;
        chk("t1_exec_busy", 8'(busy), 8'd1);
        chk("t1_exec_sel",  8'(alu_sel), 8'd0);
        chk("t1_exec_in1",  alu_in1, 8'h05);
        chk("t1_exec_in2",  alu_in2, 8'h03);
        chk("t1_exec_rv0",  8'(rsp0_valid), 8'd0);
        chk("t1_exec_rdy0", 8'(req0_ready), 8'd0);
        @(negedge clk);
        #1;
        chk("t1_resp_rv0",  8'(rsp0_valid), 8'd1);
        chk("t1_resp_rv1",  8'(rsp1_valid), 8'd0);
        chk("t1_resp_data", rsp0_data, 8'h08);
        @(negedge clk);
        #1;
        chk("t1_done_busy", 8'(busy), 8'd0);
        chk("t1_done_rv0",  8'(rsp0_valid), 8'd0);

        // Test 2/3: simultaneous requests from reset, round robin, backpressure on port 1
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd1; req0_a = 8'd16;  req0_b = 8'd17;
        req1_valid = 1'b1; req1_op = 4'd0; req1_a = 8'd200; req1_b = 8'd100;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t2_tie_rdy0", 8'(req0_ready), 8'd1);
        chk("t2_tie_rdy1", 8'(req1_ready), 8'd0);
        @(negedge clk);
        req0_op = 4'd0; req0_a = 8'd1; req0_b = 8'd1;
        #1;
        chk("t2_exec0_sel", 8'(alu_sel), 8'd1);
        chk("t2_exec0_in1", alu_in1, 8'h10);
        chk("t2_exec0_in2", alu_in2, 8'h11);
        @(negedge clk);
        #1;
        chk("t2_resp0_rv0",  8'(rsp0_valid), 8'd1);
        chk("t2_resp0_rv1",  8'(rsp1_valid), 8'd0);
        chk("t2_resp0_data", rsp0_data, 8'h10);
        @(negedge clk);
        rsp1_ready = 1'b0;
        #1;
        chk("t2_rr_rdy1", 8'(req1_ready), 8'd1);
        chk("t2_rr_rdy0", 8'(req0_ready), 8'd0);
        @(negedge clk);
        #1;
        chk("t2_exec1_sel", 8'(alu_sel), 8'd0);
        chk("t2_exec1_in1", alu_in1, 8'd200);
        chk("t2_exec1_in2", alu_in2, 8'd100);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("t3_hold_rv1",  8'(rsp1_valid), 8'd1);
            chk("t3_hold_data", rsp1_data, 8'h2C);
            chk("t3_hold_rv0",  8'(rsp0_valid), 8'd0);
            chk("t3_hold_rdy0", 8'(req0_ready), 8'd0);
            chk("t3_hold_rdy1", 8'(req1_ready), 8'd0);
            chk("t3_hold_busy", 8'(busy), 8'd1);
        end
        @(negedge clk);
        rsp1_ready = 1'b1;
        #1;
        chk("t3_take_rv1", 8'(rsp1_valid), 8'd1);
        @(negedge clk);
        #1;
        chk("t3_idle_busy", 8'(busy), 8'd0);
        chk("t2_again_rdy0", 8'(req0_ready), 8'd1);
        chk("t2_again_rdy1", 8'(req1_ready), 8'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("t2_again_rv0",   8'(rsp0_valid), 8'd1);
        chk("t2_again_data",  rsp0_data, 8'h02);
        @(negedge clk);
        #1;
        chk("t2_again_idle", 8'(busy), 8'd0);

        // Test 4: reset in the middle of EXEC aborts the op
        req1_valid = 1'b1; req1_op = 4'd1; req1_a = 8'd3; req1_b = 8'd4;
        #1;
        chk("t4_accept_rdy1", 8'(req1_ready), 8'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        chk("t4_exec_busy", 8'(busy), 8'd1);
        #2;
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd2; req0_a = 8'h5A; req0_b = 8'h11;
        #1;
        chk_all_zero("t4_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t4_rel_rdy0", 8'(req0_ready), 8'd1);
        chk("t4_rel_rv1",  8'(rsp1_valid), 8'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("t4_exec_rv1", 8'(rsp1_valid), 8'd0);
        chk("t4_exec_sel", 8'(alu_sel), 8'd2);
        @(negedge clk);
        #1;
        chk("t4_resp_rv0",  8'(rsp0_valid), 8'd1);
        chk("t4_resp_rv1",  8'(rsp1_valid), 8'd0);
        chk("t4_resp_data", rsp0_data, 8'h5A);
        @(negedge clk);
        #1;
        chk("t4_done_busy", 8'(busy), 8'd0);
        chk("t4_done_rv1",  8'(rsp1_valid), 8'd0);

        // Test 6: lone requester on port 1, back-to-back
        req1_valid = 1'b1; req1_op = 4'd0; req1_b = 8'd1; rsp1_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            if (j != 0) @(negedge clk);
            if (j % 3 == 0) req1_a = 8'(8'h10 + j / 3);
            #1;
            chk("t6_rdy1", 8'(req1_ready), 8'(j % 3 == 0));
            chk("t6_rdy0", 8'(req0_ready), 8'd0);
            chk("t6_rv1",  8'(rsp1_valid), 8'(j % 3 == 2));
            if (j % 3 == 2) chk("t6_data", rsp1_data, 8'(17 + j / 3));
        end
        req1_valid = 1'b0;

        // Test 5: latency-3 instance, pass-through op on port 1
        @(negedge clk);
        x_req1_valid = 1'b1; x_req1_op = 4'h7; x_req1_a = 8'hAB; x_req1_b = 8'h12; x_rsp1_ready = 1'b1;
        #1;
        chk("t5_accept_rdy1", 8'(x_req1_ready), 8'd1);
        @(negedge clk);
        x_req1_valid = 1'b0; x_req1_a = 8'h00;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            chk("t5_exec_busy", 8'(x_busy), 8'd1);
            chk("t5_exec_sel",  8'(x_alu_sel), 8'h7);
            chk("t5_exec_in1",  x_alu_in1, 8'hAB);
            chk("t5_exec_in2",  x_alu_in2, 8'h12);
            chk("t5_exec_rv1",  8'(x_rsp1_valid), 8'd0);
        end
        @(negedge clk);
        #1;
        chk("t5_resp_rv1",  8'(x_rsp1_valid), 8'd1);
        chk("t5_resp_data", x_rsp1_data, 8'hAB);
        @(negedge clk);
        #1;
        chk("t5_done_busy", 8'(x_busy), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
